// File: rtl/fetch_queue.sv
// fetch_queue: pipelined instruction fetch with prefetch FIFO, redirect flush and stale-response discard.
// Define FETCH_PERF_EN to add saturating perf_fetched/perf_flushed/perf_stall counters.
module fetch_queue #(
  parameter int PC_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [PC_WIDTH-1:0]   out_pc_plus4,
  output logic [DATA_WIDTH-1:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushed,
  output logic [31:0]           perf_stall
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int QW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAXO = CW'(MAX_OUTSTANDING);
  localparam logic [QW-1:0] QLAST = QW'(MAX_OUTSTANDING - 1);

  logic [PC_WIDTH-1:0]   fetch_pc;
  logic [PC_WIDTH-1:0]   rq [MAX_OUTSTANDING];
  logic [QW-1:0]         rq_wr, rq_rd;
  logic [PC_WIDTH-1:0]   fifo_pc [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_instr [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, inflight, discard;
  logic [CW:0]           occupancy;
  logic                  req_fire, drop, push, pop, unused_low_bits;

  function automatic logic [QW-1:0] rq_next(input logic [QW-1:0] p);
    return p == QLAST ? '0 : p + 1'b1;
  endfunction

  // Responses still owed to live requests reserve their FIFO slot up front.
  assign occupancy = {1'b0, count} + {1'b0, inflight} - {1'b0, discard};
  assign imem_req_valid = rst && !redirect_valid && inflight < MAXO && occupancy < FULL;
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign drop = imem_rsp_valid && discard != '0;
  assign push = imem_rsp_valid && discard == '0 && !redirect_valid;
  assign pop = out_valid && out_ready && !redirect_valid;
  assign out_valid = count != '0;
  assign out_pc = out_valid ? fifo_pc[rd_ptr] : '0;
  assign out_pc_plus4 = out_valid ? fifo_pc[rd_ptr] + PC_WIDTH'(4) : '0;
  assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
  assign unused_low_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rq_wr <= '0;
      rq_rd <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      inflight <= '0;
      discard <= '0;
    end else begin
      fetch_pc <= redirect_valid ? {redirect_pc[PC_WIDTH-1:2], 2'b00} : req_fire ? fetch_pc + PC_WIDTH'(4) : fetch_pc;
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      discard <= redirect_valid ? inflight - CW'(imem_rsp_valid) : discard - CW'(drop);
      if (req_fire) rq_wr <= rq_next(rq_wr);
      if (imem_rsp_valid) rq_rd <= rq_next(rq_rd);
      wr_ptr <= redirect_valid ? '0 : wr_ptr + PW'(push);
      rd_ptr <= redirect_valid ? '0 : rd_ptr + PW'(pop);
      count <= redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) rq[rq_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[wr_ptr] <= rq[rq_rd];
      fifo_instr[wr_ptr] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, 32'(pop));
      perf_flushed <= sat_add(perf_flushed, redirect_valid ? 32'(count) + 32'(imem_rsp_valid) : 32'(drop));
      perf_stall <= sat_add(perf_stall, 32'(out_valid && !out_ready));
    end
  end
`endif
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch stage: owns the PC, issues pipelined requests to instruction memory, buffers returned instructions in a prefetch FIFO, and hands {pc, pc+4, instr} to the IF/ID register over a valid/ready handshake.
- Replaces the single-cycle, combinational-memory fetch path. It supports variable-latency memory, multiple outstanding requests, and redirect-flush with discard of stale responses.

Parameters:
- PC_WIDTH, 32, PC and address width.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- MAX_OUTSTANDING, 2, maximum in-flight memory requests; at least 1, at most DEPTH.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; state is cleared while rst=0.
- redirect_valid  in  1  branch/jump resolved taken; flush and refetch.
- redirect_pc  in  PC_WIDTH  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  PC_WIDTH  request address.
- imem_rsp_valid  in  1  response valid; responses return in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  DATA_WIDTH  instruction word.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts; low means stall.
- out_pc  out  PC_WIDTH  PC of the head instruction.
- out_pc_plus4  out  PC_WIDTH  out_pc + 4, modulo 2^PC_WIDTH.
- out_instr  out  DATA_WIDTH  head instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; discard=0.
  - imem_req_valid=0, out_valid=0; out_pc, out_pc_plus4 and out_instr are all 0.
- Issue condition: imem_req_valid=1 when all of the following hold:
  - rst deasserted;
  - !redirect_valid;
  - inflight < MAX_OUTSTANDING;
  - fifo_count + (inflight − discard) < DEPTH.
  - Together these guarantee every accepted response has a FIFO slot, so there is no overflow and no response backpressure.
- Request handshake:
  - imem_req_addr=fetch_pc.
  - On valid&&ready: fetch_pc += 4 (wraps modulo 2^PC_WIDTH); a request PC queue records fetch_pc.
  - The request PC queue has MAX_OUTSTANDING entries, in-order.
- inflight counter:
  - +1 on request accept, −1 on imem_rsp_valid; both in the same cycle leaves it unchanged.
- Response handling:
  - If discard>0: drop the data, discard−1, pop the request PC queue.
  - Otherwise: push {pc from the request PC queue, data} into the FIFO.
- Output:
  - out_* driven from the FIFO head; out_valid = (fifo_count != 0).
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are both honoured, and count is unchanged; this applies when full as well.
  - Outputs hold stable while out_valid && !out_ready.
- Redirect (cycle T, redirect_valid=1):
  - The FIFO is cleared at edge T; a pop in cycle T is ignored.
  - fetch_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00}; the low bits are forced to zero.
  - discard = inflight − (imem_rsp_valid && discard==0 ? 1 : 0) − (imem_rsp_valid && discard>0 ? 1 : 0); that is, every request still outstanding after edge T is discarded.
  - imem_req_valid=0 during cycle T.
  - The first new-path request is at T+1.
  - Back-to-back redirects: the last one wins, and discard is recomputed each time.
- Latency: with 1-cycle memory and out_ready=1, out_valid is first asserted 2 cycles after reset release or after a redirect. Sustained throughput is 1 instruction/cycle when MAX_OUTSTANDING ≥ 2.
- Memory accept is never forced: imem_req_valid stays high, with a stable address, until ready, unless a redirect withdraws it.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs perf_fetched, perf_flushed and perf_stall, each 32-bit, saturating, and reset to 0.
  - perf_fetched: +1 per out handshake.
  - perf_flushed: +(FIFO entries cleared + responses discarded), counted as each is dropped.
  - perf_stall: +1 per cycle with out_valid && !out_ready.
- Undefined: these ports and their logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset release, 1-cycle memory, out_ready=1 -> output sequence pc 0x0, 0x4, 0x8, ...; out_pc_plus4 = pc+4; one instruction per cycle from the second cycle after release.
- out_ready=0 for 10 cycles, DEPTH=4 -> FIFO holds 4 entries, imem_req_valid=0, head fixed at pc 0x0. Release -> 0x0, 0x4, 0x8, 0xC delivered in order with no loss or duplicates.
- 3-cycle memory latency, 2 requests in flight, redirect to 0x100 -> both stale responses dropped; the next out_pc is 0x100, then 0x104.
- Redirect to 0x203 -> fetch restarts at 0x200.
- Redirect in the same cycle as out handshake and response arrival -> nothing from the old path appears after the redirect; inflight returns to 0.
- PC wrap: RESET_PC=0xFFFFFFF8 -> out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0. With FETCH_PERF_EN, perf_fetched equals the number of handshakes and perf_stall equals the count of stall cycles.
